// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message pre-processing path.
//   SHA256_WORD_W      : width of one message word
//   SHA256_BLOCK_W     : width of one compression block
//   SHA256_LEN_FIELD_W : width of the trailing message-length field
//   SHA256_PAD_BYTE    : first padding byte appended after the message
//   pad_state_e        : state encoding of sha256_msg_padder
package sha256_pkg;

   localparam int unsigned SHA256_WORD_W      = 32;
   localparam int unsigned SHA256_BLOCK_W     = 512;
   localparam int unsigned SHA256_LEN_FIELD_W = 64;
   localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;

   typedef enum logic [2:0] {
      StAccept,
      StOutData,
      StOutFinal,
      StOutSpill,
      StOutLen
   } pad_state_e;

endpackage

// File: rtl/sha256_pad_insert.sv
// Combinational last-word masker for the SHA-256 padder.
//   data_i   : last message word, byte 0 in [31:24]
//   nbytes_i : valid bytes in data_i (0..4, larger values mean 4)
//   word_o   : data_i with invalid bytes zeroed and the pad byte placed right after the
//              last valid byte (nothing inserted when all four bytes are valid)
//   carry_o  : word was full, so the pad byte belongs at the top of the next word
module sha256_pad_insert
   import sha256_pkg::*;
(
   input  logic [SHA256_WORD_W-1:0] data_i,
   input  logic [2:0]               nbytes_i,
   output logic [SHA256_WORD_W-1:0] word_o,
   output logic                     carry_o
);

   logic [2:0] nb;

   always_comb begin
      nb     = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
      word_o = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < nb) begin
            word_o[31-8*i -: 8] = data_i[31-8*i -: 8];
         end else if (3'(i) == nb) begin
            word_o[31-8*i -: 8] = SHA256_PAD_BYTE;
         end
      end
      carry_o = (nb == 3'd4);
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: collects 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 byte, zero fill and the 64-bit bit-length, and presents each block on a
// valid/ready handshake with a last-block flag.
//   ACLK, ARESETn     : clock, asynchronous active-low reset
//   s_valid/s_ready   : input word handshake (ready only while collecting)
//   s_data            : message bytes, byte 0 in [31:24]
//   s_last, s_nbytes  : final word marker and its valid byte count (0..4, 5..7 mean 4)
//   blk_valid/ready   : output block handshake
//   blk_data          : W0 in [511:480] .. W15 in [31:0]
//   blk_last          : block is the final block of the message
//   len_ovf           : only with SHA256_PAD_OVF_EN; sticky bit-counter wrap flag, cleared
//                       when the final block is taken
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int unsigned LEN_WIDTH = 64
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [SHA256_WORD_W-1:0]  s_data,
   input  logic                      s_last,
   input  logic [2:0]                s_nbytes,
   output logic                      blk_valid,
   input  logic                      blk_ready,
   output logic [SHA256_BLOCK_W-1:0] blk_data,
   output logic                      blk_last
`ifdef SHA256_PAD_OVF_EN
   ,output logic                     len_ovf
`endif
);

   // One extra sum bit only when the wrap has to be observed.
`ifdef SHA256_PAD_OVF_EN
   localparam int unsigned SumW = LEN_WIDTH + 1;
`else
   localparam int unsigned SumW = LEN_WIDTH;
`endif

   pad_state_e                 state_q, state_d;
   logic [SHA256_WORD_W-1:0]   wbuf_q [16];
   logic [SHA256_WORD_W-1:0]   wbuf_d [16];
   logic [3:0]                 widx_q, widx_d;
   logic [LEN_WIDTH-1:0]       bitcnt_q, bitcnt_d;
   logic                       blk_last_q, blk_last_d;
   logic                       pad16_q, pad16_d;

   logic [SHA256_WORD_W-1:0]      pad_word;
   logic                          pad_carry;
   logic [2:0]                    nb;
   logic [SumW-1:0]               cnt_inc, cnt_sum;
   logic [SHA256_LEN_FIELD_W-1:0] len_new, len_cur;
   logic [4:0]                    pad_pos;
   logic                          s_fire, b_fire;

   sha256_pad_insert u_pad_insert (
      .data_i   (s_data),
      .nbytes_i (s_nbytes),
      .word_o   (pad_word),
      .carry_o  (pad_carry)
   );

   assign s_ready   = (state_q == StAccept);
   assign blk_valid = (state_q != StAccept);
   assign blk_last  = blk_last_q;
   assign s_fire    = s_valid && s_ready;
   assign b_fire    = blk_valid && blk_ready;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         blk_data[SHA256_BLOCK_W-1-32*i -: 32] = wbuf_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      wbuf_d     = wbuf_q;
      widx_d     = widx_q;
      bitcnt_d   = bitcnt_q;
      blk_last_d = blk_last_q;
      pad16_d    = pad16_q;

      nb          = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
      cnt_inc     = '0;
      cnt_inc[5:0] = s_last ? {nb, 3'b000} : 6'd32;
      cnt_sum     = SumW'(bitcnt_q) + cnt_inc;
      len_new     = '0;
      len_new[LEN_WIDTH-1:0] = cnt_sum[LEN_WIDTH-1:0];
      len_cur     = '0;
      len_cur[LEN_WIDTH-1:0] = bitcnt_q;
      // Word index that receives the 0x80 byte (16 means it spills into the next block).
      pad_pos     = {1'b0, widx_q} + {4'b0000, pad_carry};

      unique case (state_q)
         StAccept: begin
            if (s_fire) begin
               bitcnt_d = cnt_sum[LEN_WIDTH-1:0];
               if (!s_last) begin
                  wbuf_d[widx_q] = s_data;
                  widx_d         = widx_q + 4'd1;
                  if (widx_q == 4'd15) begin
                     state_d    = StOutData;
                     blk_last_d = 1'b0;
                  end
               end else begin
                  for (int i = 0; i < 16; i++) begin
                     if (5'(i) > pad_pos) wbuf_d[i] = '0;
                  end
                  wbuf_d[widx_q] = pad_word;
                  if (pad_carry && (widx_q != 4'd15)) begin
                     wbuf_d[widx_q + 4'd1] = {SHA256_PAD_BYTE, 24'h000000};
                  end
                  pad16_d = pad_carry && (widx_q == 4'd15);
                  if (pad_pos <= 5'd13) begin
                     wbuf_d[14] = len_new[63:32];
                     wbuf_d[15] = len_new[31:0];
                     state_d    = StOutFinal;
                     blk_last_d = 1'b1;
                  end else begin
                     state_d    = StOutSpill;
                     blk_last_d = 1'b0;
                  end
               end
            end
         end
         StOutData: begin
            if (b_fire) begin
               state_d = StAccept;
               widx_d  = '0;
            end
         end
         StOutSpill: begin
            if (b_fire) begin
               for (int i = 0; i < 16; i++) wbuf_d[i] = '0;
               if (pad16_q) wbuf_d[0] = {SHA256_PAD_BYTE, 24'h000000};
               wbuf_d[14] = len_cur[63:32];
               wbuf_d[15] = len_cur[31:0];
               blk_last_d = 1'b1;
               state_d    = StOutLen;
            end
         end
         StOutFinal, StOutLen: begin
            if (b_fire) begin
               bitcnt_d   = '0;
               widx_d     = '0;
               blk_last_d = 1'b0;
               state_d    = StAccept;
            end
         end
         default: state_d = StAccept;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= StAccept;
         wbuf_q     <= '{default: '0};
         widx_q     <= '0;
         bitcnt_q   <= '0;
         blk_last_q <= 1'b0;
         pad16_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wbuf_q     <= wbuf_d;
         widx_q     <= widx_d;
         bitcnt_q   <= bitcnt_d;
         blk_last_q <= blk_last_d;
         pad16_q    <= pad16_d;
      end
   end

`ifdef SHA256_PAD_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (s_fire && cnt_sum[LEN_WIDTH]) ovf_d = 1'b1;
      if (b_fire && ((state_q == StOutFinal) || (state_q == StOutLen))) ovf_d = 1'b0;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   assign len_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a byte-level padding model pushes expected blocks
// when a message is driven; a consumer pops and compares each block as it appears.
module tb_sha256_msg_padder;
   import sha256_pkg::*;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {
      logic [511:0] data;
      logic         last;
   } blk_t;

   logic         ACLK;
   logic         ARESETn;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         s_last;
   logic [2:0]   s_nbytes;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_last;
`ifdef SHA256_PAD_OVF_EN
   logic         len_ovf;
`endif

   int   n_checks;
   int   n_errors;
   int   stall_cycles;
   blk_t sb[$];

   sha256_msg_padder dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_nbytes  (s_nbytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last)
`ifdef SHA256_PAD_OVF_EN
      ,.len_ovf  (len_ovf)
`endif
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference FIPS 180-4 padding at byte granularity.
   task automatic push_expect(input bytes_t msg);
      bytes_t       p;
      logic [63:0]  len;
      blk_t         b;
      int           nblk;
      p   = msg;
      len = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
      nblk = p.size() / 64;
      for (int k = 0; k < nblk; k++) begin
         b.data = '0;
         for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[64*k+j];
         b.last = (k == nblk - 1);
         sb.push_back(b);
      end
   endtask

   function automatic bytes_t make_rand(input int n);
      bytes_t m;
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      return m;
   endfunction

   task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
      int t;
      t        = 0;
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = l;
      s_nbytes = nb;
      while (s_ready !== 1'b1 && t < 500) begin
         @(negedge ACLK);
         t++;
      end
      if (t >= 500) check_eq("s_ready_timeout", 512'(s_ready), 512'(1));
      @(negedge ACLK);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Invalid bytes carry random garbage; big_nb reports a full last word as 7.
   task automatic send_msg(input bytes_t msg, input logic big_nb);
      int          n, nw, nb;
      logic [31:0] w;
      logic        l;
      n  = msg.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         w = $urandom;
         for (int b = 0; b < 4; b++) begin
            if (4*k + b < n) w[31-8*b -: 8] = msg[4*k+b];
         end
         l  = (k == nw - 1);
         nb = l ? (n - 4*(nw-1)) : int'($urandom_range(0, 7));
         if (l && nb == 4 && big_nb) nb = 7;
         send_word(w, l, 3'(nb));
      end
      check_eq("latency_blk_valid", 512'(blk_valid), 512'(1));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || blk_valid === 1'b1) && t < 2000) begin
         @(negedge ACLK);
         t++;
      end
      check_eq("drain", 512'(sb.size()), 512'(0));
   endtask

   task automatic check_reset_state();
      check_eq("rst_s_ready", 512'(s_ready), 512'(1));
      check_eq("rst_blk_valid", 512'(blk_valid), 512'(0));
      check_eq("rst_blk_last", 512'(blk_last), 512'(0));
      check_eq("rst_blk_data", blk_data, 512'(0));
   endtask

   initial begin : consumer
      blk_t         exp;
      logic [511:0] held;
      logic         hl;
      blk_ready = 1'b0;
      forever begin
         @(negedge ACLK);
         if (blk_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_blk", 512'(sb.size()), 512'(1));
               exp = '0;
            end else begin
               exp = sb.pop_front();
            end
            check_eq("blk_data", blk_data, exp.data);
            check_eq("blk_last", 512'(blk_last), 512'(exp.last));
            held = blk_data;
            hl   = blk_last;
            for (int k = 0; k < stall_cycles; k++) begin
               @(negedge ACLK);
               check_eq("hold_data", blk_data, held);
               check_eq("hold_last", 512'(blk_last), 512'(hl));
               check_eq("hold_valid", 512'(blk_valid), 512'(1));
               check_eq("stall_s_ready", 512'(s_ready), 512'(0));
            end
            blk_ready = 1'b1;
            @(negedge ACLK);
            blk_ready = 1'b0;
            if (exp.last) check_eq("reentry_s_ready", 512'(s_ready), 512'(1));
         end
      end
   end

   initial begin : stimulus
      bytes_t m;
      n_checks     = 0;
      n_errors     = 0;
      stall_cycles = 0;
      ARESETn      = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      s_last       = 1'b0;
      s_nbytes     = '0;
      repeat (3) @(negedge ACLK);
      check_reset_state();
      ARESETn = 1'b1;
      @(negedge ACLK);

      m = {8'h61, 8'h62, 8'h63};
      push_expect(m);
      send_msg(m, 1'b0);
      m = {};
      push_expect(m);
      send_msg(m, 1'b0);
      foreach (m[i]) m.delete(i);
      m = make_rand(56);
      push_expect(m);
      send_msg(m, 1'b0);
      m = make_rand(64);
      push_expect(m);
      send_msg(m, 1'b1);
      m = make_rand(55);
      push_expect(m);
      send_msg(m, 1'b0);
      m = make_rand(60);
      push_expect(m);
      send_msg(m, 1'b0);
      m = make_rand(130);
      push_expect(m);
      send_msg(m, 1'b0);
      wait_drain();

      stall_cycles = 5;
      m = make_rand(64);
      push_expect(m);
      send_msg(m, 1'b0);
      m = make_rand(56);
      push_expect(m);
      send_msg(m, 1'b0);
      wait_drain();
      stall_cycles = 0;

      // Abort a message after five words; the next one must start from a clean count.
      m = make_rand(20);
      for (int k = 0; k < 5; k++) begin
         send_word({m[4*k], m[4*k+1], m[4*k+2], m[4*k+3]}, 1'b0, 3'd0);
      end
      ARESETn = 1'b0;
      @(negedge ACLK);
      check_reset_state();
      ARESETn = 1'b1;
      @(negedge ACLK);
      m = {8'h61, 8'h62, 8'h63};
      push_expect(m);
      send_msg(m, 1'b0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
